// File: rtl/spu_pkg.sv
// spu_pkg
//   Shared definitions for the 16-bit SPU core front end: machine word
//   width, PC increment, the HALT opcode, the fetch FSM state type and the
//   {instr, pc} record carried from fetch toward decode.
package spu_pkg;

    localparam int unsigned XLEN = 16;

    localparam logic [3:0]      OPC_HALT = 4'hF;
    localparam logic [XLEN-1:0] PC_STEP  = 16'd2;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   DEPTH-entry synchronous FIFO of fetched {instr, pc} records.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     push, wdata  write request and record (ignored when full without pop)
//     pop          read request (ignored when empty)
//     flush        empties the FIFO; dominates push and pop
//     rdata        head record (stale contents when empty)
//     full, empty  occupancy flags
module fetch_fifo
    import spu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_rd_ptr;
    logic [AW-1:0]  r_wr_ptr;
    logic [AW:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);
    assign rdata = r_mem[r_rd_ptr];

    assign w_do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: it is only observed while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (!flush && w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch for the SPU core. Owns the PC, reads one instruction
//   per cycle from the combinational instruction ROM and queues {instr, pc}
//   toward decode. Redirects flush the queue and reload the PC; a fetched
//   HALT stops fetching until the next redirect.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     imem_addr         ROM byte address (current PC)
//     imem_rdata        ROM data for imem_addr
//     redirect_valid    branch/jump taken; redirect_pc is the target
//     if_valid/if_ready handshake toward decode
//     if_instr/if_pc    head instruction and its fetch address
//     halted            HALT fetched, fetching stopped
module fetch_stage
    import spu_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic        halted
);

    logic [15:0]  r_pc;
    fetch_state_t r_state;
    fetch_entry_t r_last;

    fetch_entry_t w_head;
    fetch_entry_t w_wdata;
    logic         w_full;
    logic         w_empty;
    logic         w_pop;
    logic         w_push;
    logic         w_unused;

    assign w_unused = redirect_pc[0];

    assign w_pop  = !w_empty && if_ready;
    assign w_push = (r_state == RUN) && !redirect_valid && (!w_full || w_pop);

    assign w_wdata.instr = imem_rdata;
    assign w_wdata.pc    = r_pc;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect_valid),
        .wdata (w_wdata),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_state <= RUN;
            r_last  <= '0;
        end else begin
            // Decode consumes the head even when a redirect discards the rest.
            if (w_pop) begin
                r_last <= w_head;
            end
            if (redirect_valid) begin
                r_pc    <= {redirect_pc[15:1], 1'b0};
                r_state <= RUN;
            end else if (w_push) begin
                r_pc <= r_pc + PC_STEP;
                if (imem_rdata[15:12] == OPC_HALT) begin
                    r_state <= HALTED;
                end
            end
        end
    end

    // With the queue empty the head outputs show the last consumed record.
    always_comb begin
        if_instr = w_head.instr;
        if_pc    = w_head.pc;
        if (w_empty) begin
            if_instr = r_last.instr;
            if_pc    = r_last.pc;
        end
    end

    assign imem_addr = r_pc;
    assign if_valid  = !w_empty;
    assign halted    = (r_state == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int unsigned DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [49:0] RST_VEC  = {1'b0, 16'h0000, 16'h0000, RESET_PC, 1'b0};

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        halted;

    logic [15:0] halt_addr;
    logic [15:0] rom_seed;

    int unsigned n_tests;
    int unsigned n_fail;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [15:0] m_pc;
    logic        m_halt;
    ent_t        m_last;

    fetch_stage #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: pseudo-random non-HALT words, HALT only at halt_addr.
    function automatic logic [15:0] rom_word(input logic [15:0] a, input logic [15:0] h,
                                             input logic [15:0] s);
        logic [15:0] w;
        if (a == h) return {4'hF, a[11:0]};
        w = (a * 16'h9E37) ^ s;
        if (w[15:12] == 4'hF) w[15] = 1'b0;
        return w;
    endfunction

    always_comb imem_rdata = rom_word(imem_addr, halt_addr, rom_seed);

    wire [49:0] dut_vec = {if_valid, if_instr, if_pc, imem_addr, halted};

    function automatic logic [49:0] exp_vec();
        ent_t h;
        h = (q.size() != 0) ? q[0] : m_last;
        return {(q.size() != 0), h.instr, h.pc, m_pc, m_halt};
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc   = RESET_PC;
        m_halt = 1'b0;
        m_last = '0;
    endtask

    // Drive one cycle of inputs, advance the reference model across the edge,
    // and return #1 after that edge.
    task automatic cycle(input logic rv, input logic [15:0] rpc, input logic rdy);
        logic        pop;
        logic [15:0] word;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        pop = (q.size() != 0) && rdy;
        if (pop) m_last = q[0];
        if (rv) begin
            q.delete();
            m_pc   = {rpc[15:1], 1'b0};
            m_halt = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (!m_halt && q.size() < DEPTH) begin
                word = rom_word(m_pc, halt_addr, rom_seed);
                q.push_back({word, m_pc});
                if (word[15:12] == 4'hF) m_halt = 1'b1;
                m_pc = m_pc + 16'd2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        if_ready       = 1'b0;
        rst_n          = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (dut_vec !== RST_VEC) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", dut_vec, RST_VEC);
        end
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_stream();
        halt_addr = 16'h0001;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 16'h0000, 1'b1);
            n_tests++;
            if (dut_vec !== exp_vec() || if_pc !== 16'(2 * i) || if_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stream[%0d]: got %h expected %h (if_pc %h)", i, dut_vec, exp_vec(), if_pc);
            end
        end
    endtask

    task automatic test_back_to_back();
        halt_addr = 16'h0001;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 16'h0000, 1'b0);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL stall[%0d]: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        n_tests++;
        if (imem_addr !== 16'h0004 || if_valid !== 1'b1 || if_pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL stall_hold: got addr %h valid %b pc %h expected addr 0004 valid 1 pc 0000",
                     imem_addr, if_valid, if_pc);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (if_valid !== 1'b1 || if_pc !== 16'(2 * i)) begin
                n_fail++;
                $display("FAIL drain_seq[%0d]: got valid %b pc %h expected valid 1 pc %h",
                         i, if_valid, if_pc, 16'(2 * i));
            end
            cycle(1'b0, 16'h0000, 1'b1);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL drain[%0d]: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_redirect_full();
        // FIFO is full here (continues from test_back_to_back); pop is discarded.
        cycle(1'b1, 16'h0009, 1'b1);
        n_tests++;
        if (if_valid !== 1'b0 || imem_addr !== 16'h0008 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL redirect_bubble: got %h expected %h", dut_vec, exp_vec());
        end
        cycle(1'b0, 16'h0000, 1'b1);
        n_tests++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0008 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL redirect_target: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_halt();
        halt_addr = 16'h0006;
        do_reset();
        for (int i = 0; i < 8 && !halted; i++) begin
            cycle(1'b0, 16'h0000, 1'b1);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL halt_run[%0d]: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        n_tests++;
        if (halted !== 1'b1 || imem_addr !== 16'h0008 || if_pc !== 16'h0006 || if_instr[15:12] !== 4'hF) begin
            n_fail++;
            $display("FAIL halt_rise: got halted %b addr %h pc %h instr %h expected 1 0008 0006 Fxxx",
                     halted, imem_addr, if_pc, if_instr);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 16'h0000, 1'b1);
            n_tests++;
            if (dut_vec !== exp_vec() || imem_addr !== 16'h0008 || halted !== 1'b1) begin
                n_fail++;
                $display("FAIL halt_hold[%0d]: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        n_tests++;
        if (if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_drained: got valid %b expected 0", if_valid);
        end
        cycle(1'b1, 16'h0000, 1'b1);
        n_tests++;
        if (halted !== 1'b0 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL halt_clear: got %h expected %h", dut_vec, exp_vec());
        end
        cycle(1'b0, 16'h0000, 1'b1);
        n_tests++;
        if (if_valid !== 1'b1 || if_pc !== 16'h0000 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL halt_resume: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_wrap();
        halt_addr = 16'h0001;
        cycle(1'b1, 16'hFFFE, 1'b1);
        cycle(1'b0, 16'h0000, 1'b1);
        n_tests++;
        if (if_pc !== 16'hFFFE || if_valid !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL wrap_top: got %h expected %h", dut_vec, exp_vec());
        end
        cycle(1'b0, 16'h0000, 1'b1);
        n_tests++;
        if (if_pc !== 16'h0000 || if_valid !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL wrap_zero: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_async_reset();
        halt_addr = 16'h0002;
        do_reset();
        cycle(1'b0, 16'h0000, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0);
        n_tests++;
        if (halted !== 1'b1 || if_valid !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL pre_reset: got %h expected %h", dut_vec, exp_vec());
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (dut_vec !== RST_VEC) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", dut_vec, RST_VEC);
        end
        model_reset();
        #2;
        rst_n = 1'b1;
        cycle(1'b0, 16'h0000, 1'b1);
        n_tests++;
        if (if_pc !== RESET_PC || if_valid !== 1'b1 || dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_restart: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        logic        rv;
        logic [15:0] rpc;
        logic        rdy;
        halt_addr = {10'd0, 5'($urandom_range(0, 31)), 1'b0};
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) halt_addr = {10'd0, 5'($urandom_range(0, 31)), 1'b0};
            rv  = ($urandom_range(0, 15) == 0);
            rpc = 16'($urandom_range(0, 63));
            rdy = ($urandom_range(0, 3) != 0);
            cycle(rv, rpc, rdy);
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        if_ready       = 1'b0;
        halt_addr      = 16'h0001;
        rom_seed       = 16'($urandom);
        model_reset();

        test_reset();
        test_stream();
        test_back_to_back();
        test_redirect_full();
        test_halt();
        test_wrap();
        test_async_reset();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
